// File: rtl/tcp_rt_timer_engine.sv
// -----------------------------------------------------------------------------
// tcp_rt_timer_engine
//   TX-side per-flow TCP retransmit engine. Tracks snd_una/snd_nxt and one
//   retransmit timer per flow. Consumes RX ack/dup-ack state and issues
//   retransmit requests to the TX segment builder on RTO expiry or when the
//   dup-ack count reaches threshold (fast retransmit).
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   arm_*           TX sent data on a flow; arm_seq_num becomes snd_nxt
//   ack_*           RX cumulative ack number and dup-ack count for a flow
//   rt_req_*        retransmit request (flow, seq = snd_una, cause)
//   ack_rdy         1 outside reset; arm_rdy = ~ack_val (ack has priority)
// -----------------------------------------------------------------------------
module tcp_rt_timer_engine #(
    parameter int unsigned     FLOWS          = 8,
    parameter int unsigned     FLOWID_W       = 3,
    parameter int unsigned     SEQ_W          = 32,
    parameter int unsigned     TIMESTAMP_W    = 64,
    parameter longint unsigned TIMEOUT_CYCLES = 64'd250000000,
    parameter int unsigned     DUP_ACK_CNT_W  = 4,
    parameter int unsigned     DUP_ACK_RT     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm_val,
    input  logic [FLOWID_W-1:0]      arm_flowid,
    input  logic [SEQ_W-1:0]         arm_seq_num,
    output logic                     arm_rdy,
    input  logic                     ack_val,
    input  logic [FLOWID_W-1:0]      ack_flowid,
    input  logic [SEQ_W-1:0]         ack_num,
    input  logic [DUP_ACK_CNT_W-1:0] ack_dup_cnt,
    output logic                     ack_rdy,
    output logic                     rt_req_val,
    output logic [FLOWID_W-1:0]      rt_req_flowid,
    output logic [SEQ_W-1:0]         rt_req_seq,
    output logic                     rt_req_timeout,
    input  logic                     rt_req_rdy
);

    localparam logic [TIMESTAMP_W-1:0]   TIMEOUT_TS = TIMESTAMP_W'(TIMEOUT_CYCLES);
    localparam logic [DUP_ACK_CNT_W-1:0] DUP_RT     = DUP_ACK_CNT_W'(DUP_ACK_RT);
    localparam logic [FLOWID_W-1:0]      LAST_FLOW  = FLOWID_W'(FLOWS - 1);
    localparam logic [FLOWID_W:0]        FLOWS_EXT  = (FLOWID_W+1)'(FLOWS);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    // Per-flow state
    logic [FLOWS-1:0]       armed_q, armed_d;
    logic [FLOWS-1:0]       fast_done_q, fast_done_d;
    logic [FLOWS-1:0]       pend_q, pend_d;
    logic [FLOWS-1:0]       pend_to_q, pend_to_d;
    logic [TIMESTAMP_W-1:0] ts_q [FLOWS];
    logic [TIMESTAMP_W-1:0] ts_d [FLOWS];
    logic [SEQ_W-1:0]       snd_una_q [FLOWS];
    logic [SEQ_W-1:0]       snd_una_d [FLOWS];
    logic [SEQ_W-1:0]       snd_nxt_q [FLOWS];
    logic [SEQ_W-1:0]       snd_nxt_d [FLOWS];

    // Global state
    logic [TIMESTAMP_W-1:0] now_q;
    logic [FLOWID_W-1:0]    scan_ptr_q, scan_ptr_d;
    logic [FLOWID_W-1:0]    rr_ptr_q, rr_ptr_d;
    state_t                 state_q, state_d;
    logic                   out_val_q, out_val_d;
    logic [FLOWID_W-1:0]    out_flow_q, out_flow_d;
    logic [SEQ_W-1:0]       out_seq_q, out_seq_d;
    logic                   out_to_q, out_to_d;

    // Combinational helpers
    logic                   ack_fire, arm_fire;
    logic [SEQ_W-1:0]       ack_una, ack_nxt, ack_diff, ack_ext;
    logic                   ack_new, ack_dup;
    logic [TIMESTAMP_W-1:0] scan_elapsed;
    logic                   scan_hit, scan_blocked;
    logic                   accept, withdraw;
    logic [FLOWS-1:0]       pend_eff;
    logic                   pick_found;
    logic [FLOWID_W-1:0]    pick_flow;
    logic [FLOWID_W:0]      pick_sum;

    assign ack_rdy  = ~rst;
    assign arm_rdy  = ~rst & ~ack_val;
    assign ack_fire = ack_val & ack_rdy;
    assign arm_fire = arm_val & arm_rdy;

    // Serial-number comparisons: new ack iff snd_una < ack_num <= snd_nxt
    assign ack_una  = snd_una_q[ack_flowid];
    assign ack_nxt  = snd_nxt_q[ack_flowid];
    assign ack_diff = ack_num - ack_una;
    assign ack_ext  = ack_nxt - ack_num;
    assign ack_new  = ack_fire && (ack_diff != '0) && !ack_diff[SEQ_W-1] && !ack_ext[SEQ_W-1];
    assign ack_dup  = ack_fire && (ack_diff == '0) && (ack_dup_cnt >= DUP_RT) &&
                      armed_q[ack_flowid] && !fast_done_q[ack_flowid] && !pend_q[ack_flowid];

    assign scan_elapsed = now_q - ts_q[scan_ptr_q];
    assign scan_hit     = armed_q[scan_ptr_q] && !pend_q[scan_ptr_q] && (scan_elapsed >= TIMEOUT_TS);
    assign scan_blocked = (ack_fire && (ack_flowid == scan_ptr_q)) ||
                          (arm_fire && (arm_flowid == scan_ptr_q));
    assign scan_ptr_d   = (scan_ptr_q == LAST_FLOW) ? '0 : scan_ptr_q + 1'b1;

    assign accept   = (state_q == S_HOLD) && rt_req_rdy;
    assign withdraw = (state_q == S_HOLD) && ack_new && (ack_flowid == out_flow_q);

    // A flow being new-acked this cycle must not be picked from stale pend.
    assign pend_eff = pend_q & ~(ack_new ? (FLOWS'(1) << ack_flowid) : '0);

    // Round-robin pick: first pending flow at or after rr_ptr
    always_comb begin
        pick_found = 1'b0;
        pick_flow  = '0;
        pick_sum   = '0;
        for (int unsigned i = 0; i < FLOWS; i++) begin
            pick_sum = {1'b0, rr_ptr_q} + (FLOWID_W+1)'(i);
            if (pick_sum >= FLOWS_EXT) begin
                pick_sum = pick_sum - FLOWS_EXT;
            end
            if (!pick_found && pend_eff[pick_sum[FLOWID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_flow  = pick_sum[FLOWID_W-1:0];
            end
        end
    end

    // Output stage
    always_comb begin
        state_d    = state_q;
        out_val_d  = out_val_q;
        out_flow_d = out_flow_q;
        out_seq_d  = out_seq_q;
        out_to_d   = out_to_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    out_val_d  = 1'b1;
                    out_flow_d = pick_flow;
                    out_seq_d  = snd_una_q[pick_flow];
                    out_to_d   = pend_to_q[pick_flow];
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                // A completed handshake stands even if a new ack arrives with it;
                // the ack's per-flow update still takes priority below.
                if (accept) begin
                    out_val_d = 1'b0;
                    rr_ptr_d  = (out_flow_q == LAST_FLOW) ? '0 : out_flow_q + 1'b1;
                    state_d   = S_IDLE;
                end else if (withdraw) begin
                    out_val_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                out_val_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Per-flow next state; later writes take priority: scan < accept < arm/ack
    always_comb begin
        armed_d     = armed_q;
        fast_done_d = fast_done_q;
        pend_d      = pend_q;
        pend_to_d   = pend_to_q;
        ts_d        = ts_q;
        snd_una_d   = snd_una_q;
        snd_nxt_d   = snd_nxt_q;

        if (scan_hit && !scan_blocked) begin
            pend_d[scan_ptr_q]    = 1'b1;
            pend_to_d[scan_ptr_q] = 1'b1;
        end

        if (accept) begin
            pend_d[out_flow_q] = 1'b0;
            if (out_to_q) begin
                ts_d[out_flow_q] = now_q;
            end else begin
                fast_done_d[out_flow_q] = 1'b1;
            end
        end

        if (arm_fire) begin
            snd_nxt_d[arm_flowid] = arm_seq_num;
            if (!armed_q[arm_flowid]) begin
                armed_d[arm_flowid] = 1'b1;
                ts_d[arm_flowid]    = now_q;
            end
        end

        if (ack_new) begin
            snd_una_d[ack_flowid]   = ack_num;
            fast_done_d[ack_flowid] = 1'b0;
            pend_d[ack_flowid]      = 1'b0;
            if (ack_num == ack_nxt) begin
                armed_d[ack_flowid] = 1'b0;
            end else begin
                ts_d[ack_flowid] = now_q;
            end
        end else if (ack_dup) begin
            pend_d[ack_flowid]    = 1'b1;
            pend_to_d[ack_flowid] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            now_q       <= '0;
            scan_ptr_q  <= '0;
            rr_ptr_q    <= '0;
            state_q     <= S_IDLE;
            out_val_q   <= 1'b0;
            out_flow_q  <= '0;
            out_seq_q   <= '0;
            out_to_q    <= 1'b0;
            armed_q     <= '0;
            fast_done_q <= '0;
            pend_q      <= '0;
            pend_to_q   <= '0;
            for (int unsigned i = 0; i < FLOWS; i++) begin
                ts_q[i]      <= '0;
                snd_una_q[i] <= '0;
                snd_nxt_q[i] <= '0;
            end
        end else begin
            now_q       <= now_q + 1'b1;
            scan_ptr_q  <= scan_ptr_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= state_d;
            out_val_q   <= out_val_d;
            out_flow_q  <= out_flow_d;
            out_seq_q   <= out_seq_d;
            out_to_q    <= out_to_d;
            armed_q     <= armed_d;
            fast_done_q <= fast_done_d;
            pend_q      <= pend_d;
            pend_to_q   <= pend_to_d;
            for (int unsigned i = 0; i < FLOWS; i++) begin
                ts_q[i]      <= ts_d[i];
                snd_una_q[i] <= snd_una_d[i];
                snd_nxt_q[i] <= snd_nxt_d[i];
            end
        end
    end

    assign rt_req_val     = out_val_q;
    assign rt_req_flowid  = out_flow_q;
    assign rt_req_seq     = out_seq_q;
    assign rt_req_timeout = out_to_q;

endmodule

// File: tb/tb_tcp_rt_timer_engine.sv
// -----------------------------------------------------------------------------
// tb_tcp_rt_timer_engine
//   Directed bench for tcp_rt_timer_engine with TIMEOUT_CYCLES = 100.
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_tcp_rt_timer_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm_val = 1'b0;
    logic [2:0]  arm_flowid = '0;
    logic [31:0] arm_seq_num = '0;
    logic        arm_rdy;
    logic        ack_val = 1'b0;
    logic [2:0]  ack_flowid = '0;
    logic [31:0] ack_num = '0;
    logic [3:0]  ack_dup_cnt = '0;
    logic        ack_rdy;
    logic        rt_req_val;
    logic [2:0]  rt_req_flowid;
    logic [31:0] rt_req_seq;
    logic        rt_req_timeout;
    logic        rt_req_rdy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    tcp_rt_timer_engine #(
        .FLOWS          (8),
        .FLOWID_W       (3),
        .SEQ_W          (32),
        .TIMESTAMP_W    (64),
        .TIMEOUT_CYCLES (100),
        .DUP_ACK_CNT_W  (4),
        .DUP_ACK_RT     (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .arm_val        (arm_val),
        .arm_flowid     (arm_flowid),
        .arm_seq_num    (arm_seq_num),
        .arm_rdy        (arm_rdy),
        .ack_val        (ack_val),
        .ack_flowid     (ack_flowid),
        .ack_num        (ack_num),
        .ack_dup_cnt    (ack_dup_cnt),
        .ack_rdy        (ack_rdy),
        .rt_req_val     (rt_req_val),
        .rt_req_flowid  (rt_req_flowid),
        .rt_req_seq     (rt_req_seq),
        .rt_req_timeout (rt_req_timeout),
        .rt_req_rdy     (rt_req_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        arm_val    = 1'b0;
        ack_val    = 1'b0;
        rt_req_rdy = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic arm(input logic [2:0] f, input logic [31:0] s);
        arm_val     = 1'b1;
        arm_flowid  = f;
        arm_seq_num = s;
        tick();
        arm_val = 1'b0;
    endtask

    task automatic ack(input logic [2:0] f, input logic [31:0] n, input logic [3:0] dup);
        ack_val     = 1'b1;
        ack_flowid  = f;
        ack_num     = n;
        ack_dup_cnt = dup;
        tick();
        ack_val = 1'b0;
    endtask

    // Cycles until rt_req_val is seen, bounded by max_cyc
    task automatic wait_rt(input int max_cyc, output int k);
        k = 0;
        while (rt_req_val !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
    endtask

    task automatic count_val(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            tick();
            if (rt_req_val === 1'b1) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int c;

        // Reset state
        repeat (3) tick();
        check("rst_val",     rt_req_val,     0);
        check("rst_flowid",  rt_req_flowid,  0);
        check("rst_seq",     rt_req_seq,     0);
        check("rst_timeout", rt_req_timeout, 0);
        check("rst_ack_rdy", ack_rdy,        0);
        check("rst_arm_rdy", arm_rdy,        0);
        rst = 1'b0;
        #1;
        check("ack_rdy_on", ack_rdy, 1);
        check("arm_rdy_on", arm_rdy, 1);
        ack_val = 1'b1;
        ack_flowid = 3'd7;
        ack_num = '0;
        ack_dup_cnt = '0;
        #1;
        check("arm_rdy_blocked", arm_rdy, 0);
        ack_val = 1'b0;
        #1;

        // 1: RTO on f2; re-arm does not restart the timer; periodic repeat
        do_reset();
        rt_req_rdy = 1'b1;
        arm(3'd2, 32'd1000);
        repeat (49) tick();
        arm(3'd2, 32'd1500);
        wait_rt(70, k);
        check("t1_seen",       rt_req_val, 1);
        check("t1_no_restart", (k >= 50 && k <= 60), 1);
        check("t1_flowid",     rt_req_flowid, 2);
        check("t1_seq",        rt_req_seq, 0);
        check("t1_timeout",    rt_req_timeout, 1);
        tick();
        check("t1_drop", rt_req_val, 0);
        wait_rt(120, k);
        check("t1_repeat_gap",  (k >= 100 && k <= 110), 1);
        check("t1_repeat_flow", rt_req_flowid, 2);

        // 2: full ack disarms
        do_reset();
        rt_req_rdy = 1'b1;
        arm(3'd1, 32'd500);
        repeat (20) tick();
        ack(3'd1, 32'd500, 4'd0);
        count_val(300, c);
        check("t2_no_rt", c, 0);

        // 3: ack above snd_nxt ignored; partial ack restarts timer
        do_reset();
        rt_req_rdy = 1'b1;
        arm(3'd3, 32'd800);
        repeat (19) tick();
        ack(3'd3, 32'd900, 4'd0);
        repeat (29) tick();
        ack(3'd3, 32'd400, 4'd0);
        wait_rt(120, k);
        check("t3_latency", (k >= 100 && k <= 110), 1);
        check("t3_flowid",  rt_req_flowid, 3);
        check("t3_seq",     rt_req_seq, 400);
        check("t3_timeout", rt_req_timeout, 1);

        // 4: fast retransmit once per new ack
        do_reset();
        rt_req_rdy = 1'b1;
        arm(3'd0, 32'd900);
        ack(3'd0, 32'd300, 4'd0);
        ack(3'd0, 32'd300, 4'd3);
        tick();
        check("t4_val",     rt_req_val, 1);
        check("t4_flowid",  rt_req_flowid, 0);
        check("t4_seq",     rt_req_seq, 300);
        check("t4_timeout", rt_req_timeout, 0);
        tick();
        check("t4_drop", rt_req_val, 0);
        ack(3'd0, 32'd300, 4'd4);
        count_val(20, c);
        check("t4_no_repeat", c, 0);
        ack(3'd0, 32'd400, 4'd0);
        ack(3'd0, 32'd400, 4'd3);
        tick();
        check("t4_rearm_val",     rt_req_val, 1);
        check("t4_rearm_seq",     rt_req_seq, 400);
        check("t4_rearm_timeout", rt_req_timeout, 0);

        // 5: new ack withdraws a held request and disarms
        do_reset();
        rt_req_rdy = 1'b0;
        arm(3'd4, 32'd700);
        ack(3'd4, 32'd200, 4'd0);
        ack(3'd4, 32'd200, 4'd3);
        tick();
        check("t5_val",    rt_req_val, 1);
        check("t5_flowid", rt_req_flowid, 4);
        check("t5_seq",    rt_req_seq, 200);
        repeat (3) tick();
        check("t5_hold", rt_req_val, 1);
        ack(3'd4, 32'd700, 4'd0);
        check("t5_withdrawn", rt_req_val, 0);
        rt_req_rdy = 1'b1;
        count_val(150, c);
        check("t5_disarmed", c, 0);

        // 6: round-robin order 1, 5, 6; reset mid-HOLD
        do_reset();
        rt_req_rdy = 1'b0;
        arm(3'd1, 32'd100);
        repeat (9) tick();
        arm(3'd5, 32'd100);
        arm(3'd6, 32'd100);
        wait_rt(130, k);
        check("t6_first_val",  rt_req_val, 1);
        check("t6_first_flow", rt_req_flowid, 1);
        repeat (30) tick();
        check("t6_hold_val",  rt_req_val, 1);
        check("t6_hold_flow", rt_req_flowid, 1);
        rt_req_rdy = 1'b1;
        tick();
        check("t6_gap1", rt_req_val, 0);
        tick();
        check("t6_second_val",  rt_req_val, 1);
        check("t6_second_flow", rt_req_flowid, 5);
        tick();
        check("t6_gap2", rt_req_val, 0);
        tick();
        rt_req_rdy = 1'b0;
        check("t6_third_val",     rt_req_val, 1);
        check("t6_third_flow",    rt_req_flowid, 6);
        check("t6_third_timeout", rt_req_timeout, 1);
        check("t6_third_seq",     rt_req_seq, 0);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_drop",   rt_req_val, 0);
        check("t6_rst_flowid", rt_req_flowid, 0);
        tick();
        rst = 1'b0;
        tick();
        rt_req_rdy = 1'b1;
        count_val(150, c);
        check("t6_none_after_rst", c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
